// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 timing defaults and helpers shared by the VGA sync generator and decoder
package vga_timing_pkg;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_FRONT_PORCH = 18;
  localparam int H_BACK_PORCH = 50;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_BACK_PORCH = 33;
  localparam int H_SYNC_WIDTH = H_TOTAL - H_ACTIVE - H_FRONT_PORCH - H_BACK_PORCH;
  localparam int V_SYNC_WIDTH = V_TOTAL - V_ACTIVE - V_FRONT_PORCH - V_BACK_PORCH;
  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} lock_state_t;
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return &v ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers a sync input and flags the sample where it falls from 1 to 0
module vga_sync_edge (
  input  logic clk,
  input  logic rst_l,
  input  logic sync,
  output logic fall
);
  logic cur, prev;
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cur <= 1'b1;
      prev <= 1'b1;
    end else begin
      cur <= sync;
      prev <= cur;
    end
  end
  assign fall = prev & ~cur;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers VGA line/frame timing, tracks lock and emits aligned pixel coordinates and video
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS = H_TOTAL,
  parameter int TOTAL_ROWS = V_TOTAL,
  parameter int ACTIVE_COLS = H_ACTIVE,
  parameter int ACTIVE_ROWS = V_ACTIVE,
  parameter int FRONT_PORCH_HORZ = H_FRONT_PORCH,
  parameter int FRONT_PORCH_VERT = V_FRONT_PORCH
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_Locked,
  output logic                   o_Active,
  output logic [9:0]             o_Col_Count,
  output logic [9:0]             o_Row_Count,
  output logic                   o_Frame_Start,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);
  localparam logic [9:0] H_START = 10'(TOTAL_COLS - ACTIVE_COLS - FRONT_PORCH_HORZ);
  localparam logic [9:0] H_END = 10'(TOTAL_COLS - FRONT_PORCH_HORZ);
  localparam logic [9:0] V_START = 10'(TOTAL_ROWS - ACTIVE_ROWS - FRONT_PORCH_VERT);
  localparam logic [9:0] V_END = 10'(TOTAL_ROWS - FRONT_PORCH_VERT);
  localparam logic [10:0] H_LEN = 11'(TOTAL_COLS);
  localparam logic [10:0] V_LEN = 11'(TOTAL_ROWS);
  logic h_fall, v_fall, pending, h_seen, frame_good;
  logic frame_load, line_err, frame_ok, visible, act;
  logic [9:0] h_pos, v_pos;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q, red_d, grn_d, blu_d;
  lock_state_t state;
  vga_sync_edge u_hsync (.clk(i_Clk), .rst_l(i_Rst_L), .sync(i_HSync), .fall(h_fall));
  vga_sync_edge u_vsync (.clk(i_Clk), .rst_l(i_Rst_L), .sync(i_VSync), .fall(v_fall));
  assign frame_load = h_fall & (pending | v_fall);
  assign line_err = (h_fall & h_seen & (({1'b0, h_pos} + 11'd1) != H_LEN)) | (&h_pos);
  assign frame_ok = ({1'b0, v_pos} + 11'd1) == V_LEN;
  assign visible = h_pos >= H_START && h_pos < H_END && v_pos >= V_START && v_pos < V_END;
  assign act = visible && state == LOCKED;
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      h_pos <= '0;
      v_pos <= '0;
      pending <= 1'b0;
    end else begin
      h_pos <= h_fall ? '0 : sat_inc(h_pos);
      v_pos <= !h_fall ? v_pos : frame_load ? '0 : sat_inc(v_pos);
      pending <= !h_fall & (pending | v_fall);
    end
  end
  // A line error coinciding with a frame load in CHECK blocks the lock but still re-arms for the new frame
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state <= UNLOCKED;
      frame_good <= 1'b0;
      h_seen <= 1'b0;
    end else begin
      h_seen <= h_seen | h_fall;
      case (state)
        UNLOCKED: if (frame_load) begin
          state <= CHECK;
          frame_good <= 1'b1;
        end
        CHECK: if (frame_load) begin
          state <= (frame_good && frame_ok && !line_err) ? LOCKED : CHECK;
          frame_good <= 1'b1;
        end else if (line_err) frame_good <= 1'b0;
        LOCKED: if (line_err || (frame_load && !frame_ok)) begin
          state <= UNLOCKED;
          h_seen <= 1'b0;
        end
        default: state <= UNLOCKED;
      endcase
    end
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_Locked <= 1'b0;
      o_Active <= 1'b0;
      o_Col_Count <= '0;
      o_Row_Count <= '0;
      o_Frame_Start <= 1'b0;
      {red_q, grn_q, blu_q} <= '0;
      {red_d, grn_d, blu_d} <= '0;
      {o_Red_Video, o_Grn_Video, o_Blu_Video} <= '0;
    end else begin
      o_Locked <= state == LOCKED;
      o_Active <= act;
      o_Col_Count <= act ? h_pos - H_START : '0;
      o_Row_Count <= act ? v_pos - V_START : '0;
      o_Frame_Start <= act && h_pos == H_START && v_pos == V_START;
      {red_q, grn_q, blu_q} <= {i_Red_Video, i_Grn_Video, i_Blu_Video};
      {red_d, grn_d, blu_d} <= {red_q, grn_q, blu_q};
      {o_Red_Video, o_Grn_Video, o_Blu_Video} <= {red_d, grn_d, blu_d};
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: frame-recipe table plus per-cycle reference model for the VGA sync decoder
module tb_vga_sync_decoder;
  localparam int VW = 3;
  localparam int TC = 64;
  localparam int TR = 40;
  localparam int AC = 40;
  localparam int AR = 24;
  localparam int FPH = 6;
  localparam int FPV = 4;
  localparam int HST = TC - AC - FPH;
  localparam int VST = TR - AR - FPV;
  localparam int HSW = 8;
  localparam int VSW = 2;
  localparam int K_NOM = 0, K_LONG = 1, K_EARLY = 2, K_HOLD = 3, K_RST = 4, K_RAND = 5;
  localparam int S_U = 0, S_C = 1, S_L = 2;

  typedef struct packed {
    logic locked;
    logic active;
    logic [9:0] col;
    logic [9:0] row;
    logic fs;
    logic [VW-1:0] r;
    logic [VW-1:0] g;
    logic [VW-1:0] b;
  } out_t;

  typedef struct {
    int kind;
    int exp_lock;
    int exp_act;
    int exp_fs;
  } frame_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [VW-1:0] red = '0, grn = '0, blu = '0;
  logic locked, active, fstart;
  logic [9:0] col, row;
  logic [VW-1:0] ored, ogrn, oblu;

  vga_sync_decoder #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR), .FRONT_PORCH_HORZ(FPH), .FRONT_PORCH_VERT(FPV)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_HSync(hs), .i_VSync(vs),
    .i_Red_Video(red), .i_Grn_Video(grn), .i_Blu_Video(blu),
    .o_Locked(locked), .o_Active(active), .o_Col_Count(col), .o_Row_Count(row),
    .o_Frame_Start(fstart), .o_Red_Video(ored), .o_Grn_Video(ogrn), .o_Blu_Video(oblu)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int act_cnt, fs_cnt, hold_act;
  bit in_hold = 0, chk_zero = 0;
  out_t exp_q[$];

  // Reference state: sample index, index of the last HSync fall, lines since frame load
  int n = 0, last_fall = 0, lines = 0, st = S_U;
  bit pend = 0, seen = 0, good = 0, m_ph = 1, m_pv = 1;

  function automatic int sat(input int x);
    return x > 1023 ? 1023 : x;
  endfunction

  task automatic model(input logic h, input logic v, input logic rl,
                       input logic [VW-1:0] r, input logic [VW-1:0] g, input logic [VW-1:0] b);
    int hp, hn;
    bit fh, fv, load, lerr, fok, unlock, vis;
    out_t e;
    if (!rl) begin
      last_fall = n - 1;
      lines = 0; st = S_U;
      pend = 0; seen = 0; good = 0; m_ph = 1; m_pv = 1;
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
      n++;
      return;
    end
    hp = sat(n - 1 - last_fall);
    fh = m_ph && !h;
    fv = m_pv && !v;
    load = fh && (pend || fv);
    lerr = (fh && seen && hp + 1 != TC) || hp == 1023;
    fok = lines + 1 == TR;
    unlock = 0;
    if (st == S_U) begin
      if (load) begin st = S_C; good = 1; end
    end else if (st == S_C) begin
      if (load) begin st = (good && fok && !lerr) ? S_L : S_C; good = 1; end
      else if (lerr) good = 0;
    end else if (lerr || (load && !fok)) begin
      st = S_U; unlock = 1;
    end
    if (fh) begin
      last_fall = n;
      lines = load ? 0 : sat(lines + 1);
    end
    pend = !fh && (pend || fv);
    seen = !unlock && (seen || fh);
    m_ph = h; m_pv = v;
    hn = sat(n - last_fall);
    vis = hn >= HST && hn < HST + AC && lines >= VST && lines < VST + AR;
    e.locked = st == S_L;
    e.active = vis && st == S_L;
    e.col = e.active ? 10'(hn - HST) : '0;
    e.row = e.active ? 10'(lines - VST) : '0;
    e.fs = e.active && hn == HST && lines == VST;
    e.r = r; e.g = g; e.b = b;
    exp_q.push_back(e);
    n++;
  endtask

  task automatic cycle(input logic h, input logic v, input logic rl,
                       input logic [VW-1:0] r, input logic [VW-1:0] g, input logic [VW-1:0] b);
    out_t got, e;
    @(negedge clk);
    got = {locked, active, col, row, fstart, ored, ogrn, oblu};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs sample=%0d got=%h exp=%h", n, got, e);
      end
      if (got.active === 1'b1) begin
        checks++;
        if (got.r !== got.col[VW-1:0]) begin
          errors++;
          $display("FAIL video_align sample=%0d red=%0d col=%0d", n, got.r, got.col);
        end
      end
    end
    if (chk_zero) begin
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset_clear got=%h exp=0", got);
      end
      chk_zero = 0;
    end
    if (got.active === 1'b1) act_cnt++;
    if (got.fs === 1'b1) fs_cnt++;
    if (in_hold && got.active === 1'b1) hold_act++;
    hs = h; vs = v; rst_l = rl; red = r; grn = g; blu = b;
    chk_zero = !rl;
    model(h, v, rl, r, g, b);
  endtask

  task automatic gen_frame(input int kind);
    for (int ln = 0; ln < TR; ln++) begin
      int len;
      bit hold;
      len = TC;
      hold = 0;
      if (kind == K_LONG && ln == 5) len = TC + 1;
      if (kind == K_HOLD && ln == 3) begin len = 1100; hold = 1; end
      if (kind == K_RAND && $urandom_range(3) == 0) len = $urandom_range(TC + 2, TC - 2);
      in_hold = hold;
      for (int c = 0; c < len; c++)
        cycle(hold || c >= HSW, !(ln < VSW || (kind == K_EARLY && ln == TR - 1 && c >= 5)),
              !(kind == K_RST && ln == 20 && c == 30), VW'(c - HST), VW'($urandom), VW'($urandom));
      in_hold = 0;
      if (hold) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL hold_unlock locked=%b exp=0", locked);
        end
      end
    end
  endtask

  frame_t tbl[19];

  initial begin
    tbl = '{
      '{K_NOM, 0, 0, 0}, '{K_NOM, 1, AC * AR, 1}, '{K_NOM, 1, AC * AR, 1},
      '{K_LONG, 0, 0, 0}, '{K_NOM, 0, 0, 0}, '{K_NOM, 1, AC * AR, 1},
      '{K_EARLY, 1, AC * AR, 1}, '{K_NOM, 1, AC * AR, 1},
      '{K_HOLD, 0, 0, 0}, '{K_NOM, 0, 0, 0}, '{K_NOM, 1, AC * AR, 1},
      '{K_RST, 0, 8 * AC + 10, 1}, '{K_NOM, 0, 0, 0}, '{K_NOM, 1, AC * AR, 1},
      '{K_RAND, -1, -1, -1}, '{K_RAND, -1, -1, -1}, '{K_NOM, -1, -1, -1},
      '{K_NOM, -1, -1, -1}, '{K_NOM, 1, AC * AR, 1}
    };
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
    hold_act = 0;
    for (int f = 0; f < 19; f++) begin
      act_cnt = 0;
      fs_cnt = 0;
      gen_frame(tbl[f].kind);
      if (tbl[f].exp_lock >= 0) begin
        checks += 3;
        if (locked !== 1'(tbl[f].exp_lock)) begin
          errors++;
          $display("FAIL frame%0d_locked got=%b exp=%0d", f, locked, tbl[f].exp_lock);
        end
        if (act_cnt != tbl[f].exp_act) begin
          errors++;
          $display("FAIL frame%0d_active_count got=%0d exp=%0d", f, act_cnt, tbl[f].exp_act);
        end
        if (fs_cnt != tbl[f].exp_fs) begin
          errors++;
          $display("FAIL frame%0d_frame_start got=%0d exp=%0d", f, fs_cnt, tbl[f].exp_fs);
        end
      end
    end
    checks++;
    if (hold_act != 0) begin
      errors++;
      $display("FAIL hold_active got=%0d exp=0", hold_act);
    end
    repeat (4) cycle(1'b1, 1'b1, 1'b1, '0, '0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA sync/porch generator. Takes a raw VGA stream (HSync, VSync, RGB) with porches, recovers line and frame timing, and tracks lock to the expected mode. Outputs pixel coordinates, an active-video flag and video delayed to match, for frame capture or test-pattern checking in loopback. Default mode is 640x480 at a 25 MHz pixel clock.

Parameters:
VIDEO_WIDTH, 3, bits per colour channel
TOTAL_COLS, 800, clocks per line including sync and porches
TOTAL_ROWS, 525, lines per frame including sync and porches
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
FRONT_PORCH_HORZ, 18, clocks from end of active video to HSync fall
FRONT_PORCH_VERT, 10, lines from end of active video to VSync fall

Ports:
i_Clk  in  1  pixel clock
i_Rst_L  in  1  reset, synchronous, active-low
i_HSync  in  1  horizontal sync, active-low pulse, idle high
i_VSync  in  1  vertical sync, active-low pulse, idle high
i_Red_Video / i_Grn_Video / i_Blu_Video  in  VIDEO_WIDTH each  input video
o_Locked  out  1  timing matches parameters
o_Active  out  1  current output pixel is visible and o_Locked=1
o_Col_Count  out  10  active column 0..ACTIVE_COLS-1; 0 when not active
o_Row_Count  out  10  active row 0..ACTIVE_ROWS-1; 0 when not active
o_Frame_Start  out  1  one-cycle pulse on pixel (0,0) while locked
o_Red_Video / o_Grn_Video / o_Blu_Video  out  VIDEO_WIDTH each  video aligned to o_Active

Behaviour:
- One clock domain: i_Clk. Reset is synchronous and active-low. i_Rst_L=0 at a clock edge clears all outputs, counters and the FSM. Sync history registers reset to 1 so the first sample after reset cannot produce a false edge. Reset mid-frame drops lock on the next edge.
- Latency: 2 clocks. Outputs after edge n+2 reflect inputs sampled at edge n. Video passes through 2 register stages.
- Edge detect: a falling edge is a sample of 0 whose previous sample was 1.
- h_pos (10 bit): loads 0 on the sample where an HSync fall is detected. Otherwise increments each clock and saturates at 1023.
- v_pos (10 bit): a VSync fall sets a pending flag. If VSync and HSync fall on the same sample, the VSync fall counts as pending for that HSync fall.
  - On an HSync fall with pending set: v_pos loads 0 and pending clears (a "frame load").
  - On an HSync fall without pending: v_pos increments and saturates at 1023.
- Active region: H_START = TOTAL_COLS - ACTIVE_COLS - FRONT_PORCH_HORZ (142). V_START = TOTAL_ROWS - ACTIVE_ROWS - FRONT_PORCH_VERT (35).
  - Visible when H_START <= h_pos < H_START+ACTIVE_COLS and V_START <= v_pos < V_START+ACTIVE_ROWS.
  - o_Col_Count = h_pos - H_START. o_Row_Count = v_pos - V_START.
- Line check: at each HSync fall, measured length = h_pos+1 and must equal TOTAL_COLS. The first HSync fall after reset or unlock is not checked. A saturated h_pos (1023) counts as a line error.
- Frame check: at each frame load, v_pos+1 must equal TOTAL_ROWS.
- FSM states: UNLOCKED, CHECK, LOCKED. The state updates on the same edge as the triggering event.
  - UNLOCKED: on a frame load go to CHECK.
  - CHECK: a line error clears the frame-good flag. At the next frame load, go to LOCKED if the flag is good and the frame check passes; otherwise stay in CHECK with the flag re-armed.
  - LOCKED: any line error or frame error goes to UNLOCKED.
- o_Locked = (state==LOCKED), registered. It appears 2 clocks after the input sample that caused the transition, consistent with the pipeline.
- o_Active and o_Frame_Start are forced to 0 when o_Locked would be 0.
- Simultaneous line error and frame load while in CHECK: the error wins and the state stays CHECK.

Decomposition:
- Shared constants file vga_timing_pkg holds the 640x480 defaults (800/525/640/480, porches 18/50/10/33), shared with the sync/porch generator.
- Sub-module vga_sync_edge: input register, previous-sample register (reset 1) and falling-edge pulse. Instantiated twice, for HSync and VSync.

Test Plan:
- Reset, then 3 nominal 640x480 frames (HSync low 92 clocks, VSync low 2 lines aligned to HSync fall) -> o_Locked=1 before the first active pixel of the 2nd frame; o_Frame_Start pulses once per frame from frame 2 on.
- Locked; pixel value = column index mod 8 -> at o_Active, o_Col_Count equals the delayed video value; exactly 640 o_Active cycles per line and 480 active lines per frame.
- Locked; one line of 801 clocks -> o_Locked=0 from 2 clocks after that HSync fall; relock after 2 further clean frame loads.
- HSync held high 1100 clocks -> h_pos saturates, o_Locked falls, o_Active=0 throughout.
- VSync falls 5 clocks after an HSync fall -> v_pos=0 on the next HSync fall; no frame error; lock retained.
- i_Rst_L=0 for 1 clock mid-frame while locked -> all outputs 0 on the next edge; lock regained after 2 frame loads.
